// File: rtl/iq_mixer_pipe_if.sv
// Sample/LO/gain input bus and I/Q result bus of the quadrature mixer.
// The master drives the samples and the slave (the mixer) returns I/Q.
interface iq_mixer_pipe_if #(
  parameter int ADC_W = 10,
  parameter int LO_W  = 10,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic [ADC_W-1:0]        adc_data;
  logic signed [LO_W-1:0]  fsin;
  logic signed [LO_W-1:0]  fcos;
  logic [1:0]              gain;
  logic                    clr_sat;
  logic                    out_valid;
  logic signed [OUT_W-1:0] i_out;
  logic signed [OUT_W-1:0] q_out;
  logic                    sat_flag;

  modport master (
    output in_valid, adc_data, fsin, fcos, gain, clr_sat,
    input  out_valid, i_out, q_out, sat_flag
  );

  modport slave (
    input  in_valid, adc_data, fsin, fcos, gain, clr_sat,
    output out_valid, i_out, q_out, sat_flag
  );
endinterface

// File: rtl/iq_mixer_pipe.sv
// Quadrature mixer: ADC sample times NCO cos/sin, gain, round and saturate, fixed latency 3.
// Define MIXER_DCBLOCK_EN to build the leaky-integrator DC blocker in front of the multipliers.
module iq_mixer_pipe #(
  parameter int ADC_W         = 10,
  parameter int LO_W          = 10,
  parameter int OUT_W         = 16,
  parameter int OFFSET_BINARY = 1,
  parameter int DC_SHIFT      = 8
) (
  input logic             clk,
  input logic             rst_n,
  iq_mixer_pipe_if.slave  bus
);
  localparam int PW = ADC_W + LO_W;
  localparam int GW = PW + 3;
  localparam int SH = PW - OUT_W;
  localparam int RW = (SH > 0) ? GW + 1 : GW - SH;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [ADC_W-1:0] x;
  logic signed [ADC_W-1:0] data_in;

  generate
    if (OFFSET_BINARY != 0) begin : g_offset_bin
      assign x = {~bus.adc_data[ADC_W-1], bus.adc_data[ADC_W-2:0]};
    end else begin : g_twos_comp
      assign x = bus.adc_data;
    end
  endgenerate

`ifdef MIXER_DCBLOCK_EN
  localparam int AW = ADC_W + DC_SHIFT + 1;
  localparam int DW = ADC_W + 2;

  logic signed [AW-1:0] acc_reg;
  logic signed [AW-1:0] dc;
  logic signed [DW-1:0] diff;

  assign dc   = acc_reg >>> DC_SHIFT;
  assign diff = DW'(x) - DW'(dc);

  always_comb begin
    data_in = diff[ADC_W-1:0];
    if (diff[DW-1:ADC_W-1] != {(DW-ADC_W+1){diff[DW-1]}})
      data_in = diff[DW-1] ? {1'b1, {(ADC_W-1){1'b0}}} : {1'b0, {(ADC_W-1){1'b1}}};
  end

  // The integrator tracks the unsaturated difference so it keeps converging while the output clips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_reg <= '0;
    else if (bus.in_valid)
      acc_reg <= acc_reg + AW'(diff);
  end
`else
  assign data_in = x;
`endif

  logic                    v1_reg, v2_reg, out_valid_reg, sat_reg;
  logic signed [ADC_W-1:0] d1_reg;
  logic signed [LO_W-1:0]  lo1_reg [2];
  logic [1:0]              gain1_reg, gain2_reg;
  logic signed [PW-1:0]    p_reg [2];
  logic signed [OUT_W-1:0] y_reg [2];
  logic signed [OUT_W-1:0] y [2];
  logic [1:0]              clip;

  // Channel 0 is I (cosine), channel 1 is Q (sine).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic signed [GW-1:0] g;
      logic signed [RW-1:0] r;

      assign g = GW'(p_reg[gi]) <<< gain2_reg;

      if (SH > 0) begin : g_round
        localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SH - 1);
        logic signed [RW-1:0] biased;
        assign biased = RW'(g) + HALF;
        assign r      = biased >>> SH;
      end else begin : g_align
        assign r = RW'(g) <<< (-SH);
      end

      assign clip[gi] = (r[RW-1:OUT_W-1] != {(RW-OUT_W+1){r[RW-1]}});
      assign y[gi]    = clip[gi] ? (r[RW-1] ? OUT_MIN : OUT_MAX) : r[OUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      sat_reg       <= 1'b0;
      d1_reg        <= '0;
      gain1_reg     <= '0;
      gain2_reg     <= '0;
      for (int k = 0; k < 2; k++) begin
        lo1_reg[k] <= '0;
        p_reg[k]   <= '0;
        y_reg[k]   <= '0;
      end
    end else begin
      v1_reg        <= bus.in_valid;
      v2_reg        <= v1_reg;
      out_valid_reg <= v2_reg;

      if (bus.in_valid) begin
        d1_reg     <= data_in;
        lo1_reg[0] <= bus.fcos;
        lo1_reg[1] <= bus.fsin;
        gain1_reg  <= bus.gain;
      end

      // Full-width product so that (-2^(N-1)) * (-2^(M-1)) stays positive.
      if (v1_reg) begin
        for (int k = 0; k < 2; k++)
          p_reg[k] <= PW'(d1_reg) * PW'(lo1_reg[k]);
        gain2_reg <= gain1_reg;
      end

      if (v2_reg) begin
        for (int k = 0; k < 2; k++)
          y_reg[k] <= y[k];
      end

      if (v2_reg && (clip != 2'b00))
        sat_reg <= 1'b1;
      else if (bus.clr_sat)
        sat_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.i_out     = y_reg[0];
  assign bus.q_out     = y_reg[1];
  assign bus.sat_flag  = sat_reg;

endmodule

// File: tb/tb_iq_mixer_pipe.sv
// Directed bench for iq_mixer_pipe with hand-computed expectations (default widths, SH=4).
// The DC-blocker scenario is built only when MIXER_DCBLOCK_EN is defined.
module tb_iq_mixer_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  iq_mixer_pipe_if #(.ADC_W(10), .LO_W(10), .OUT_W(16)) bus ();

  iq_mixer_pipe #(
    .ADC_W(10), .LO_W(10), .OUT_W(16), .OFFSET_BINARY(1), .DC_SHIFT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int adc, input int cos_v, input int sin_v, input int g);
    bus.in_valid = v;
    bus.adc_data = 10'(adc);
    bus.fcos     = 10'(cos_v);
    bus.fsin     = 10'(sin_v);
    bus.gain     = 2'(g);
  endtask

  // One valid sample followed by two idle cycles; returns when its result is on the outputs.
  task automatic send(input int adc, input int cos_v, input int sin_v, input int g);
    drive(1'b1, adc, cos_v, sin_v, g);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.i_out !== 16'sd0) begin n_fail++; $display("FAIL reset_i: got %0d expected 0", bus.i_out); end
    n_checks++; if (bus.q_out !== 16'sd0) begin n_fail++; $display("FAIL reset_q: got %0d expected 0", bus.q_out); end
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", bus.sat_flag); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_mix_basic();
    send(1023, 511, -512, 0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ov: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.i_out !== 16320) begin n_fail++; $display("FAIL basic_i: got %0d expected 16320", bus.i_out); end
    n_checks++; if (bus.q_out !== -16352) begin n_fail++; $display("FAIL basic_q: got %0d expected -16352", bus.q_out); end
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b expected 0", bus.sat_flag); end
    $display("test_mix_basic: adc=1023 cos=511 sin=-512 -> i=%0d q=%0d", bus.i_out, bus.q_out);
  endtask

  task automatic test_zero_latency();
    drive(1'b1, 512, 511, 511, 0);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_ov1: got %b expected 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_ov2: got %b expected 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_ov3: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.i_out !== 16'sd0) begin n_fail++; $display("FAIL zero_i: got %0d expected 0", bus.i_out); end
    n_checks++; if (bus.q_out !== 16'sd0) begin n_fail++; $display("FAIL zero_q: got %0d expected 0", bus.q_out); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_ov4: got %b expected 0", bus.out_valid); end
    $display("test_zero_latency: adc=512 -> i=%0d q=%0d", bus.i_out, bus.q_out);
  endtask

  task automatic test_rounding();
    send(513, 8, -9, 0);
    n_checks++; if (bus.i_out !== 16'sd1) begin n_fail++; $display("FAIL round_i_half: got %0d expected 1", bus.i_out); end
    n_checks++; if (bus.q_out !== -16'sd1) begin n_fail++; $display("FAIL round_q_neg: got %0d expected -1", bus.q_out); end
    send(513, 7, -8, 0);
    n_checks++; if (bus.i_out !== 16'sd0) begin n_fail++; $display("FAIL round_i_below: got %0d expected 0", bus.i_out); end
    n_checks++; if (bus.q_out !== 16'sd0) begin n_fail++; $display("FAIL round_q_half: got %0d expected 0", bus.q_out); end
    $display("test_rounding: last i=%0d q=%0d", bus.i_out, bus.q_out);
  endtask

  task automatic test_no_wrap();
    send(0, -512, -512, 0);
    n_checks++; if (bus.i_out !== 16384) begin n_fail++; $display("FAIL nowrap_i: got %0d expected 16384", bus.i_out); end
    n_checks++; if (bus.q_out !== 16384) begin n_fail++; $display("FAIL nowrap_q: got %0d expected 16384", bus.q_out); end
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL nowrap_sat: got %b expected 0", bus.sat_flag); end
    $display("test_no_wrap: adc=0 lo=-512 -> i=%0d q=%0d", bus.i_out, bus.q_out);
  endtask

  task automatic test_gain();
    send(1023, 511, -512, 1);
    n_checks++; if (bus.i_out !== 32640) begin n_fail++; $display("FAIL gain1_i: got %0d expected 32640", bus.i_out); end
    n_checks++; if (bus.q_out !== -32704) begin n_fail++; $display("FAIL gain1_q: got %0d expected -32704", bus.q_out); end
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL gain1_sat: got %b expected 0", bus.sat_flag); end
    send(1023, 511, -512, 2);
    n_checks++; if (bus.i_out !== 32767) begin n_fail++; $display("FAIL gain2_i: got %0d expected 32767", bus.i_out); end
    n_checks++; if (bus.q_out !== -32768) begin n_fail++; $display("FAIL gain2_q: got %0d expected -32768", bus.q_out); end
    n_checks++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL gain2_sat: got %b expected 1", bus.sat_flag); end
    bus.clr_sat = 1'b1;
    tick();
    bus.clr_sat = 1'b0;
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL gain_clr: got %b expected 0", bus.sat_flag); end
    $display("test_gain: done");
  endtask

  task automatic test_saturation();
    send(1023, 511, 0, 3);
    n_checks++; if (bus.i_out !== 32767) begin n_fail++; $display("FAIL sat_i: got %0d expected 32767", bus.i_out); end
    n_checks++; if (bus.q_out !== 16'sd0) begin n_fail++; $display("FAIL sat_q: got %0d expected 0", bus.q_out); end
    n_checks++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_set: got %b expected 1", bus.sat_flag); end
    send(1023, 511, 0, 0);
    n_checks++; if (bus.i_out !== 16320) begin n_fail++; $display("FAIL sat_next_i: got %0d expected 16320", bus.i_out); end
    n_checks++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b expected 1", bus.sat_flag); end
    bus.clr_sat = 1'b1;
    tick();
    bus.clr_sat = 1'b0;
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clr: got %b expected 0", bus.sat_flag); end
    // clr_sat lands on the same edge that registers a clipped result
    drive(1'b1, 1023, 511, 0, 3);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    tick();
    bus.clr_sat = 1'b1;
    tick();
    bus.clr_sat = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_coinc_ov: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_coinc: got %b expected 1", bus.sat_flag); end
    tick();
    n_checks++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_coinc_hold: got %b expected 1", bus.sat_flag); end
    bus.clr_sat = 1'b1;
    tick();
    bus.clr_sat = 1'b0;
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clr2: got %b expected 0", bus.sat_flag); end
    $display("test_saturation: done");
  endtask

  task automatic test_back_to_back();
    logic v_in   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   adc_in [4] = '{1023, 1023, 0, 512};
    int   cos_in [4] = '{511, 511, -512, 511};
    int   sin_in [4] = '{-512, 511, -512, 511};
    int   g_in   [4] = '{0, 3, 0, 0};
    logic ov_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   i_exp  [4] = '{16320, 16320, 16384, 0};
    int   q_exp  [4] = '{-16352, -16352, 16384, 0};
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drive(v_in[j], adc_in[j], cos_in[j], sin_in[j], g_in[j]);
      else       drive(1'b0, 0, 0, 0, 0);
      tick();
      if (j >= 2 && j < 6) begin
        n_checks++; if (bus.out_valid !== ov_exp[j-2]) begin n_fail++; $display("FAIL b2b_ov[%0d]: got %b expected %b", j-2, bus.out_valid, ov_exp[j-2]); end
        n_checks++; if (bus.i_out !== 16'(i_exp[j-2])) begin n_fail++; $display("FAIL b2b_i[%0d]: got %0d expected %0d", j-2, bus.i_out, i_exp[j-2]); end
        n_checks++; if (bus.q_out !== 16'(q_exp[j-2])) begin n_fail++; $display("FAIL b2b_q[%0d]: got %0d expected %0d", j-2, bus.q_out, q_exp[j-2]); end
        $display("test_back_to_back: slot %0d ov=%b i=%0d q=%0d", j-2, bus.out_valid, bus.i_out, bus.q_out);
      end
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_ov: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1023, 511, -512, 0);
    repeat (4) tick();
    n_checks++; if (bus.i_out !== 16320) begin n_fail++; $display("FAIL mid_pre_i: got %0d expected 16320", bus.i_out); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ov: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.i_out !== 16'sd0) begin n_fail++; $display("FAIL mid_i: got %0d expected 0", bus.i_out); end
    n_checks++; if (bus.q_out !== 16'sd0) begin n_fail++; $display("FAIL mid_q: got %0d expected 0", bus.q_out); end
    drive(1'b1, 0, -512, -512, 0);
    tick();
    tick();
    drive(1'b0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flush[%0d]: got %b expected 0", j, bus.out_valid); end
    end
    drive(1'b1, 0, -512, -512, 0);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat2: got %b expected 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_lat3: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.i_out !== 16384) begin n_fail++; $display("FAIL mid_post_i: got %0d expected 16384", bus.i_out); end
    $display("test_reset_midstream: post-reset i=%0d", bus.i_out);
  endtask

`ifdef MIXER_DCBLOCK_EN
  task automatic test_dcblock();
    drive(1'b1, 600, 511, 0, 0);
    for (int j = 0; j < 302; j++) begin
      tick();
      if (j == 2) begin
        n_checks++; if (bus.i_out !== 16'sd2811) begin n_fail++; $display("FAIL dc_first_i: got %0d expected 2811", bus.i_out); end
      end
    end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dc_ov: got %b expected 1", bus.out_valid); end
    n_checks++; if (bus.i_out > 32 || bus.i_out < -32) begin n_fail++; $display("FAIL dc_settle: got %0d expected |i|<=32", bus.i_out); end
    drive(1'b0, 0, 0, 0, 0);
    $display("test_dcblock: settled i=%0d", bus.i_out);
  endtask
`endif

  initial begin
    bus.clr_sat = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    test_reset();
`ifdef MIXER_DCBLOCK_EN
    test_dcblock();
`else
    test_mix_basic();
    test_zero_latency();
    test_rounding();
    test_no_wrap();
    test_gain();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
